// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, LSU register addresses and
// a small helper for sizing the baud counter.
package uart_pkg;

  // Transmit FSM states; one 8N1 frame walks IDLE -> START -> DATA -> STOP.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  // LSU byte-write / byte-read addresses of the UART data registers.
  localparam logic [31:0] UART_TX_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_RX_ADDR = 32'h1000_0004;

  // Serial bits per 8N1 frame (start + 8 data + stop).
  localparam int unsigned UART_FRAME_BITS = 10;

  // Baud counter width; never narrower than one bit.
  function automatic int unsigned baud_cnt_width(input int unsigned clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes in front of the UART transmitter.
// Depth must be a power of two and at least 2 so pointers wrap naturally.
// Pushes while full and pops while empty are dropped internally.
module uart_tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  output logic                       full,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy next-state; simultaneous push/pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous reset to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by LSU byte writes.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry buffer in front of the
// shifter; otherwise a byte is only accepted while the line is idle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CntW = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  uart_tx_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  // Byte handed to the FSM in IDLE, from the FIFO head or straight from the LSU.
  logic            start_req;
  logic [7:0]      start_byte;
  logic            bit_done;

  assign bit_done = (cnt_q == CntLast);

`ifdef UART_TX_FIFO_EN
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [7:0]                  fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
  logic                        fifo_push;
  logic                        fifo_pop;

  assign tx_ready   = !rst && !fifo_full;
  assign fifo_push  = tx_en && tx_ready;
  assign fifo_pop   = !rst && (state_q == IDLE) && !fifo_empty;
  assign start_req  = fifo_pop;
  assign start_byte = fifo_rdata;
  assign busy       = !rst && ((state_q != IDLE) || !fifo_empty);

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (tx_data),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );
`else
  logic unused_fifo_depth;

  // Buffer depth only matters in the FIFO build.
  assign unused_fifo_depth = ^FIFO_DEPTH;
  assign tx_ready          = !rst && (state_q == IDLE);
  assign start_req         = tx_en && tx_ready;
  assign start_byte        = tx_data;
  assign busy              = !rst && (state_q != IDLE);
`endif

  // Frame sequencing: baud counter, bit index and shifter next-state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (start_req) begin
          state_d = START;
          shift_d = start_byte;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line level follows the state being entered so tx is glitch-free from a flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 4 clocks per bit. Expected line levels
// come from the 8N1 frame rule evaluated per cycle offset.
module tb_uart_tx;

  localparam int Cpb   = 4;
  localparam int Depth = 4;
  localparam int Frame = 10 * Cpb;
`ifdef UART_TX_FIFO_EN
  localparam int Lat = 1;  // push, then pop from IDLE, then START
`else
  localparam int Lat = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_tx #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Line level t cycles into a frame carrying b (t counted from the first START cycle).
  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int k;
    k = t / Cpb;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  // Five back-to-back buffered frames 0x01..0x05, first START after edge 1, 41-cycle pitch.
  function automatic logic fifo_line(input int n);
    int k;
    int off;
    if (n < 1) return 1'b1;
    k   = (n - 1) / (Frame + 1);
    off = (n - 1) % (Frame + 1);
    if (k < 5 && off < Frame) return frame_bit(8'(k + 1), off);
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_ready", tx_ready, 1'b1);
    end
  endtask

  // Called just after a negedge with the block idle; returns at the negedge where it is idle again.
  task automatic send_frame(input logic [7:0] b, input bit inject);
    tx_en   = 1'b1;
    tx_data = b;
    for (int t = 0; t <= Frame + Lat; t++) begin
      @(negedge clk);
      if (t == 0) begin
        tx_en   = 1'b0;
        tx_data = 8'($urandom);
      end
      if (inject && t == 10) begin
        tx_en   = 1'b1;
        tx_data = 8'h33;
      end
      if (inject && t == 11) tx_en = 1'b0;
      check("frame_tx", tx, (t < Lat) ? 1'b1 : frame_bit(b, t - Lat));
      check("frame_busy", busy, t < Frame + Lat);
`ifdef UART_TX_FIFO_EN
      check("frame_ready", tx_ready, 1'b1);
`else
      check("frame_ready", tx_ready, t >= Frame);
`endif
    end
  endtask

  initial begin
    rst     = 1'b1;
    tx_en   = 1'b0;
    tx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", tx_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", tx_ready, 1'b1);

    // Quiet line after reset.
    idle_check(100);

    // Reference frame, then a frame with an ignored write mid-frame.
    send_frame(8'hA5, 1'b0);
    idle_check(3);
`ifndef UART_TX_FIFO_EN
    send_frame(8'hA5, 1'b1);
    idle_check(2 * Frame);
`endif

    // Random bytes, back-to-back at minimum gap, plus the extreme patterns.
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send_frame(8'($urandom), 1'b0);
    end
    idle_check(4);

`ifdef UART_TX_FIFO_EN
    // Fill the buffer on consecutive cycles; the sixth write meets a full FIFO.
    check("fifo_ready0", tx_ready, 1'b1);
    tx_en   = 1'b1;
    tx_data = 8'h01;
    for (int n = 0; n <= 5 * (Frame + 1) + 8; n++) begin
      @(negedge clk);
      if (n < 5) begin
        check("fifo_ready", tx_ready, (n + 1) < 5);
        tx_data = 8'(n + 2);
      end else begin
        tx_en = 1'b0;
      end
      check("fifo_tx", tx, fifo_line(n));
      check("fifo_busy", busy, n < 5 * (Frame + 1));
    end
    idle_check(4);
`endif

    // Reset in the middle of a frame.
    tx_en   = 1'b1;
    tx_data = 8'hA5;
    for (int t = 0; t <= 15; t++) begin
      @(negedge clk);
      if (t == 0) tx_en = 1'b0;
      check("pre_abort_tx", tx, (t < Lat) ? 1'b1 : frame_bit(8'hA5, t - Lat));
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", tx_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_release_ready", tx_ready, 1'b1);
    check("abort_release_busy", busy, 1'b0);
    check("abort_release_tx", tx, 1'b1);
    idle_check(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
